// File: rtl/gb_dvi_scaler.sv
// gb_dvi_scaler: raster timing, integer-scaled 2bpp framebuffer fetch and palette mapping to 24-bit RGB.
module gb_dvi_scaler #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SRC_W    = 160,
  parameter int SRC_H    = 144,
  parameter int SCALE    = 3,
  parameter int X_OFF    = 80,
  parameter int Y_OFF    = 24,
  parameter int SYNC_POL = 0,
  parameter int FB_AW    = 15
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [1:0]       i_palette_sel,
  input  logic [95:0]      i_pal_custom,
  input  logic [23:0]      i_border_rgb,
  output logic [FB_AW-1:0] o_fb_addr,
  output logic             o_fb_rd,
  input  logic [1:0]       i_fb_data,
  output logic [23:0]      o_color,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_blank_b,
  output logic             o_frame_start
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam int SW = SCALE > 1 ? $clog2(SCALE) : 1;
  localparam logic [HW-1:0] H_L = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_A = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS0 = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS1 = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] X0 = HW'(X_OFF);
  localparam logic [HW-1:0] X1 = HW'(X_OFF + SRC_W * SCALE);
  localparam logic [VW-1:0] V_L = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_A = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS0 = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS1 = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] Y0 = VW'(Y_OFF);
  localparam logic [VW-1:0] Y1 = VW'(Y_OFF + SRC_H * SCALE);
  localparam logic [SW-1:0] S_L = SW'(SCALE - 1);
  localparam logic [FB_AW-1:0] LINE = FB_AW'(SRC_W);
  localparam logic IDLE = SYNC_POL == 0;

  logic [HW-1:0]    r_h;
  logic [VW-1:0]    r_v;
  logic [SW-1:0]    r_sx, r_sy;
  logic [FB_AW-1:0] r_col, r_base;
  logic [1:0]       r_pal_sel;
  logic [95:0]      r_pal_cust;
  logic [4:0]       r_s1, r_s2;
  logic             w_hend, w_hwin, w_vwin, w_fs;
  logic [4:0]       w_s0;
  logic [7:0]       w_lvl;
  logic [23:0]      w_green, w_pal;

  assign w_hend = r_h == H_L;
  assign w_hwin = r_h >= X0 && r_h < X1;
  assign w_vwin = r_v >= Y0 && r_v < Y1;
  assign w_fs   = r_h == '0 && r_v == '0;
  // Timing flags travel with the fetch: {frame_start, vsync, hsync, active, window}
  assign w_s0 = {w_fs, r_v >= VS0 && r_v < VS1, r_h >= HS0 && r_h < HS1,
                 r_h < H_A && r_v < V_A, w_hwin && w_vwin};

  // Grey levels are index*0x55, which is the 2-bit index replicated four times
  always_comb begin
    w_lvl   = {4{i_fb_data}};
    w_green = i_fb_data == 2'd0 ? 24'h9BBC0F :
              i_fb_data == 2'd1 ? 24'h8BAC0F :
              i_fb_data == 2'd2 ? 24'h306230 : 24'h0F380F;
    w_pal   = r_pal_sel == 2'd0 ? {3{~w_lvl}} :
              r_pal_sel == 2'd1 ? w_green :
              r_pal_sel == 2'd2 ? {3{w_lvl}} : r_pal_cust[24*i_fb_data +: 24];
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || !i_enable) begin
      r_h           <= '0;
      r_v           <= '0;
      r_sx          <= '0;
      r_sy          <= '0;
      r_col         <= '0;
      r_base        <= '0;
      r_s1          <= '0;
      r_s2          <= '0;
      o_fb_addr     <= '0;
      o_fb_rd       <= 1'b0;
      o_color       <= '0;
      o_blank_b     <= 1'b0;
      o_hsync       <= IDLE;
      o_vsync       <= IDLE;
      o_frame_start <= 1'b0;
      if (i_reset) begin
        r_pal_sel  <= '0;
        r_pal_cust <= '0;
      end
    end else begin
      r_h   <= w_hend ? '0 : r_h + 1'b1;
      r_sx  <= !w_hwin || r_sx == S_L ? '0 : r_sx + 1'b1;
      r_col <= !w_hwin ? '0 : r_sx == S_L ? r_col + 1'b1 : r_col;
      if (w_hend) begin
        r_v    <= r_v == V_L ? '0 : r_v + 1'b1;
        r_sy   <= !w_vwin || r_sy == S_L ? '0 : r_sy + 1'b1;
        r_base <= !w_vwin ? '0 : r_sy == S_L ? r_base + LINE : r_base;
      end
      if (w_fs) begin
        r_pal_sel  <= i_palette_sel;
        r_pal_cust <= i_pal_custom;
      end
      o_fb_addr     <= r_base + r_col;
      o_fb_rd       <= w_s0[0];
      r_s1          <= w_s0;
      r_s2          <= r_s1;
      o_color       <= !r_s2[1] ? '0 : !r_s2[0] ? i_border_rgb : w_pal;
      o_blank_b     <= r_s2[1];
      o_hsync       <= r_s2[2] ^ IDLE;
      o_vsync       <= r_s2[3] ^ IDLE;
      o_frame_start <= r_s2[4];
    end
  end
endmodule

// File: tb/tb_gb_dvi_scaler.sv
// tb_gb_dvi_scaler: directed checks on default, SCALE=2 and a shrunken-raster build of gb_dvi_scaler.
module tb_gb_dvi_scaler;
  localparam logic [23:0] BORDER = 24'h123456;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  logic [1:0] psel_a = 2'd0;
  logic [1:0] psel_b = 2'd0;
  logic [95:0] pcust = 96'hA1A2A3_B1B2B3_C1C2C3_D1D2D3;
  logic [1:0] fb_def, fb_s2;
  logic [1:0] fb_sm = 2'd0;
  logic [14:0] def_addr, s2_addr, sm_addr;
  logic def_rd, def_hs, def_vs, def_bl, def_fs;
  logic s2_rd, s2_hs, s2_vs, s2_bl, s2_fs;
  logic sm_rd, sm_hs, sm_vs, sm_bl, sm_fs;
  logic [23:0] def_col, s2_col, sm_col;
  int n, n_chk, n_err;
  int hs_cnt, vs_cnt, bl_cnt, fs_cnt, fs_first, fs_second;

  always #5 clk = ~clk;

  gb_dvi_scaler u_def (
    .i_clock(clk), .i_reset(rst), .i_enable(en_a), .i_palette_sel(psel_a),
    .i_pal_custom(pcust), .i_border_rgb(BORDER), .o_fb_addr(def_addr), .o_fb_rd(def_rd),
    .i_fb_data(fb_def), .o_color(def_col), .o_hsync(def_hs), .o_vsync(def_vs),
    .o_blank_b(def_bl), .o_frame_start(def_fs));

  gb_dvi_scaler #(.H_ACTIVE(480), .H_FP(1), .H_SYNC(1), .H_BP(1), .SCALE(2),
                  .X_OFF(160), .Y_OFF(96)) u_s2 (
    .i_clock(clk), .i_reset(rst), .i_enable(en_a), .i_palette_sel(psel_a),
    .i_pal_custom(pcust), .i_border_rgb(BORDER), .o_fb_addr(s2_addr), .o_fb_rd(s2_rd),
    .i_fb_data(fb_s2), .o_color(s2_col), .o_hsync(s2_hs), .o_vsync(s2_vs),
    .o_blank_b(s2_bl), .o_frame_start(s2_fs));

  gb_dvi_scaler #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(12), .V_FP(1),
                  .V_SYNC(2), .V_BP(1), .SRC_W(4), .SRC_H(3), .SCALE(3), .X_OFF(2),
                  .Y_OFF(1), .SYNC_POL(1)) u_sm (
    .i_clock(clk), .i_reset(rst), .i_enable(en_b), .i_palette_sel(psel_b),
    .i_pal_custom(pcust), .i_border_rgb(BORDER), .o_fb_addr(sm_addr), .o_fb_rd(sm_rd),
    .i_fb_data(fb_sm), .o_color(sm_col), .o_hsync(sm_hs), .o_vsync(sm_vs),
    .o_blank_b(sm_bl), .o_frame_start(sm_fs));

  // Synchronous framebuffers whose content is (address + 1) mod 4
  always @(posedge clk) begin
    fb_def <= 2'(def_addr + 15'd1);
    fb_s2  <= 2'(s2_addr + 15'd1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic go(input int t);
    while (n < t) step();
  endtask

  initial begin
    n = 0; n_chk = 0; n_err = 0;
    hs_cnt = 0; vs_cnt = 0; bl_cnt = 0; fs_cnt = 0; fs_first = 0; fs_second = 0;
    repeat (3) step();
    chk("rst_color", def_col, 0);
    chk("rst_flags", {def_rd, def_bl, def_fs, def_hs, def_vs}, 5'b00011);
    chk("rst_addr", def_addr, 0);
    chk("rst_s2", {s2_hs, s2_vs, s2_bl, s2_fs, s2_rd}, 5'b11000);
    chk("rst_sm_sync", {sm_hs, sm_vs}, 2'b00);
    rst = 1'b0;
    repeat (2) step();
    chk("idle_rd", def_rd, 0);
    // Raster A: pixel p's fetch is visible at n=p, its output at n=p+2
    en_a = 1'b1;
    n = -1;
    go(1);  chk("fs_early", def_fs, 0);
    go(2);  chk("fs_pix0", {def_fs, def_bl}, 2'b11);
            chk("border_00", def_col, BORDER);
            chk("s2_fs", s2_fs, 1);
    go(3);  chk("fs_once", def_fs, 0);
    go(642); chk("blank_640", {def_bl, 24'(def_col)}, 25'h0);
    go(657); chk("hs_655", def_hs, 1);
    go(658); chk("hs_656", def_hs, 0);
    go(19279); chk("rd_79_24", def_rd, 0);
    go(19280); chk("addr_80_24", {def_rd, def_addr}, {1'b1, 15'd0});
    go(21679); chk("rd_79_27", def_rd, 0);
    go(21681); chk("col_79_27", def_col, BORDER);
    go(21683); chk("addr_83_27", def_addr, 161);
    go(21685); chk("col_83_27", def_col, 24'h555555);
    go(22159); chk("addr_559_27", {def_rd, def_addr}, {1'b1, 15'd319});
    go(22160); chk("rd_560_27", def_rd, 0);
    go(22162); chk("col_560_27", def_col, BORDER);
    go(46528); chk("s2_160_96", {s2_rd, s2_addr}, {1'b1, 15'd0});
    go(46529); chk("s2_161_96", s2_addr, 0);
    go(46530); chk("s2_162_96", s2_addr, 1);
               chk("s2_col_160", s2_col, 24'hAAAAAA);
    go(46532); chk("s2_col_162", s2_col, 24'h555555);
    go(47011); chk("s2_160_97", s2_addr, 0);
    go(47012); chk("s2_161_97", s2_addr, 0);
    go(47013); chk("s2_162_97", s2_addr, 1);
    // Raster B: 24x16 total, window x 2..13, y 1..9, active-high syncs
    en_b = 1'b1;
    n = -1;
    while (n < 769) begin
      step();
      if (n == 100) psel_b = 2'd1;
      if (n >= 2) begin
        hs_cnt += int'(sm_hs);
        vs_cnt += int'(sm_vs);
        bl_cnt += int'(sm_bl);
        if (sm_fs) begin
          if (fs_cnt == 0) fs_first = n;
          else fs_second = n;
          fs_cnt++;
        end
      end
      if (n == 2)   chk("sm_fs0", {sm_fs, sm_col}, {1'b1, BORDER});
      if (n == 127) chk("pal_old", sm_col, 24'hFFFFFF);
      if (n == 229) chk("sm_last", {sm_rd, sm_addr}, {1'b1, 15'd11});
      if (n == 230) chk("sm_14_9", sm_rd, 0);
      if (n == 253) chk("sm_13_10", sm_rd, 0);
      if (n == 511) chk("pal_new", sm_col, 24'h9BBC0F);
    end
    chk("hs_total", hs_cnt, 96);
    chk("vs_total", vs_cnt, 96);
    chk("blank_total", bl_cnt, 384);
    chk("fs_count", fs_cnt, 2);
    chk("fs_period", fs_second - fs_first, 384);
    go(897);
    rst = 1'b1;
    step();
    chk("mid_rst", {sm_rd, sm_bl, sm_fs, sm_hs, sm_vs, sm_addr, sm_col}, 44'h0);
    rst = 1'b0;
    n = -1;
    step(); chk("rst_rd0", sm_rd, 0);
    step(); chk("no_stale", {sm_bl, sm_col}, 25'h0);
    step(); chk("restart_fs", sm_fs, 1);
    go(26);  chk("restart_addr", {sm_rd, sm_addr}, {1'b1, 15'd0});
    go(30);
    en_b = 1'b0;
    step();
    chk("dis_out", {sm_rd, sm_bl, sm_fs, sm_hs, sm_col}, 28'h0);
    en_b = 1'b1;
    n = -1;
    go(1); chk("en_fs_early", sm_fs, 0);
    go(2); chk("en_fs", sm_fs, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
